// File: rtl/rvc_expander_pkg.sv
// Shared types and default constants for the compressed-instruction expander.
package rvc_expander_pkg;

    localparam int unsigned CWORD_W = 16;
    localparam int unsigned XWORD_W = 32;

    localparam logic [CWORD_W-1:0] VALID_TAG_DEFAULT    = 16'h0001;
    localparam logic [XWORD_W-1:0] ILLEGAL_WORD_DEFAULT = 32'h0001_0000;

    typedef logic [CWORD_W-1:0] cword_t;
    typedef logic [XWORD_W-1:0] xword_t;

    typedef struct packed {
        xword_t data;
        logic   illegal;
    } xentry_t;

endpackage

// File: rtl/rvc_expander_skid.sv
// Two-entry valid/ready skid buffer of expanded entries; head entry is always
// presented on out_entry, and the last popped entry is held when empty.
module rvc_expander_skid
    import rvc_expander_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  xentry_t in_entry,
    input  logic    in_valid,
    output logic    in_ready,
    output logic    out_valid,
    input  logic    out_ready,
    output xentry_t out_entry
);

    localparam int unsigned CNT_W = 2;

    logic [CNT_W-1:0] count_q, count_d;
    xentry_t          head_q, head_d;
    xentry_t          spare_q, spare_d;
    logic             live_q;
    logic             push, pop;

    assign in_ready  = live_q && (count_q != CNT_W'(2));
    assign out_valid = (count_q != CNT_W'(0));
    assign out_entry = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state: head is the visible slot, spare holds the second entry.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        spare_d = spare_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == CNT_W'(0)) head_d  = in_entry;
                else                      spare_d = in_entry;
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                if (count_q == CNT_W'(2)) head_d = spare_q;
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                // Only reachable with one entry: replace head, occupancy stays 1.
                head_d = in_entry;
            end
            default: ;
        endcase
    end

    // State registers; live_q keeps in_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            head_q  <= '0;
            spare_q <= '0;
            live_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            spare_q <= spare_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: rtl/rvc_expander.sv
// Compressed-to-32-bit instruction expander with a combinational path and a
// registered valid/ready path. Optional illegal-word counter: EXPANDER_STATS_EN.
module rvc_expander
    import rvc_expander_pkg::*;
#(
    parameter logic [15:0] VALID_TAG    = VALID_TAG_DEFAULT,
    parameter logic [31:0] ILLEGAL_WORD = ILLEGAL_WORD_DEFAULT,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] compressed,
    output logic [31:0] expanded,
    output logic        illegal,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_illegal
`ifdef EXPANDER_STATS_EN
    ,
    output logic [COUNT_W-1:0] illegal_count
`endif
);

    if (COUNT_W == 0) begin : g_bad_count_w
        $error("rvc_expander: COUNT_W must be at least 1");
    end

    function automatic xentry_t expand(input cword_t c);
        xentry_t e;
        if (c == cword_t'(0)) begin
            e.data    = ILLEGAL_WORD;
            e.illegal = 1'b1;
        end else begin
            e.data    = {c, VALID_TAG};
            e.illegal = 1'b0;
        end
        return e;
    endfunction

    xentry_t comb_entry;
    xentry_t head_entry;

    // Zero-latency expansion, independent of clock and handshake.
    always_comb begin
        comb_entry = expand(compressed);
        expanded   = comb_entry.data;
        illegal    = comb_entry.illegal;
    end

    rvc_expander_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_entry  (comb_entry),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (head_entry)
    );

    assign out_data    = head_entry.data;
    assign out_illegal = head_entry.illegal;

`ifdef EXPANDER_STATS_EN
    // Saturating count of accepted illegal words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (in_valid && in_ready && comb_entry.illegal
                     && (illegal_count != {COUNT_W{1'b1}})) begin
            illegal_count <= illegal_count + COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rvc_expander.sv
// Directed + random bench for rvc_expander with a scoreboard on the registered path.
module tb_rvc_expander;

    localparam int unsigned CW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] compressed;
    logic [31:0] expanded;
    logic        illegal;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_illegal;
`ifdef EXPANDER_STATS_EN
    logic [CW-1:0] illegal_count;
`endif

    int passed = 0;
    int total  = 0;
    logic [32:0] sb[$];
    int          cnt_model = 0;

    always #5 clk = ~clk;

    rvc_expander #(.COUNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .compressed  (compressed),
        .expanded    (expanded),
        .illegal     (illegal),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_illegal (out_illegal)
`ifdef EXPANDER_STATS_EN
        ,
        .illegal_count (illegal_count)
`endif
    );

    function automatic logic [32:0] model(input logic [15:0] c);
        if (c == 16'h0000) return {32'h0001_0000, 1'b1};
        return {c, 16'h0001, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: score handshakes seen before the edge, then check occupancy after it.
    task automatic cycle();
        logic [32:0] e;
        logic acc;
        logic pp;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        if (pp) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pop_data", {out_data, out_illegal}, e);
            end else begin
                check("spurious_valid", 33'(out_valid), 33'(0));
            end
        end
        if (acc) begin
            sb.push_back(model(compressed));
            if (compressed == 16'h0000 && cnt_model < 3) cnt_model++;
        end
        @(posedge clk);
        #1;
        check("occupancy", 33'(out_valid), 33'(sb.size() != 0));
        check("in_ready", 33'(in_ready), 33'(sb.size() < 2));
`ifdef EXPANDER_STATS_EN
        check("illegal_count", 33'(illegal_count), 33'(cnt_model));
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        compressed = 16'h0000;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("rst_out_valid", 33'(out_valid), 33'(0));
        check("rst_out_data", {out_data, out_illegal}, 33'(0));
        check("rst_in_ready", 33'(in_ready), 33'(0));
`ifdef EXPANDER_STATS_EN
        check("rst_count", 33'(illegal_count), 33'(0));
`endif
        // Combinational path, before any clock edge.
        compressed = 16'h0000; #1;
        check("comb_0000", {expanded, illegal}, {32'h0001_0000, 1'b1});
        compressed = 16'hFFFF; #1;
        check("comb_ffff", {expanded, illegal}, {32'hFFFF_0001, 1'b0});
        compressed = 16'h1234; #1;
        check("comb_1234", {expanded, illegal}, {32'h1234_0001, 1'b0});
        compressed = 16'h0001; #1;
        check("comb_0001", {expanded, illegal}, {32'h0001_0001, 1'b0});

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 33'(in_ready), 33'(1));

        // Single word with 1-cycle latency.
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        compressed = 16'h1234;
        cycle();
        in_valid = 1'b0;
        check("single_data", {out_data, out_illegal}, {32'h1234_0001, 1'b0});
        cycle();

        // Backpressure: two accepts fill the buffer, third word is held.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        compressed = 16'hFFFF;
        cycle();
        compressed = 16'h0001;
        cycle();
        compressed = 16'h0002;
        cycle();
        check("bp_full_ready", 33'(in_ready), 33'(0));
        check("bp_hold_data", {out_data, out_illegal}, {32'hFFFF_0001, 1'b0});
        out_ready = 1'b1;
        cycle();
        check("bp_second", {out_data, out_illegal}, {32'h0001_0001, 1'b0});
        cycle();
        in_valid = 1'b0;
        check("bp_third", {out_data, out_illegal}, {32'h0002_0001, 1'b0});
        cycle();
        check("empty_hold", {out_data, out_illegal}, {32'h0002_0001, 1'b0});

        // Five illegal words: counter saturates at 3.
        in_valid   = 1'b1;
        compressed = 16'h0000;
        for (int i = 0; i < 5; i++) cycle();
        in_valid = 1'b0;
        cycle();
        check("illegal_out", {out_data, out_illegal}, {32'h0001_0000, 1'b1});
`ifdef EXPANDER_STATS_EN
        check("count_saturated", 33'(illegal_count), 33'(3));
`endif

        // Asynchronous reset with a full buffer.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        compressed = 16'h00AA;
        cycle();
        cycle();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 33'(out_valid), 33'(0));
        check("midrst_in_ready", 33'(in_ready), 33'(0));
        check("midrst_out_data", {out_data, out_illegal}, 33'(0));
`ifdef EXPANDER_STATS_EN
        check("midrst_count", 33'(illegal_count), 33'(0));
`endif
        sb.delete();
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the scoreboard.
        for (int i = 0; i < 80; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            compressed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("drained", 33'(sb.size()), 33'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rvc_expander.md
# rvc_expander

Widens a 16-bit compressed instruction word into a 32-bit expanded word for the ENIAC-V fetch path, and flags the reserved all-zero word as illegal. The widening path is purely combinational, so the result is valid in the same cycle. A parallel registered path with a valid/ready handshake and a 2-entry skid buffer delivers the same result one cycle later to the decode stage.

## Interface
- `VALID_TAG`, default 16'h0001: low half-word appended to every legal word.
- `ILLEGAL_WORD`, default 32'h0001_0000: fixed expansion for the illegal word.
- `COUNT_W`, default 16: width of the illegal-word counter.

Clock, reset and ports:
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `compressed`  in  16  compressed word.
- `expanded`  out  32  combinational expansion of `compressed`.
- `illegal`  out  1  combinational; 1 when `compressed` == 16'h0000.
- `in_valid`  in  1  `compressed` is offered to the registered path.
- `in_ready`  out  1  registered path can accept a word.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  32  registered expansion.
- `out_illegal`  out  1  registered illegal flag for `out_data`.
- `illegal_count`  out  COUNT_W  illegal words accepted; present only with `EXPANDER_STATS_EN`.

## Operation
- Expansion rule:
  - `compressed` != 0: `expanded` = {`compressed`, `VALID_TAG`} and `illegal` = 0.
  - `compressed` == 0: `expanded` = `ILLEGAL_WORD` and `illegal` = 1.
- The combinational path does not depend on `clk`, `rst_n` or the handshake.
- Acceptance:
  - A word is accepted on a rising edge when `in_valid` && `in_ready`.
  - Its expansion and illegal flag are written into the skid buffer.
- Skid buffer:
  - 2 entries, FIFO order.
  - `out_data` and `out_illegal` always show the head entry.
  - Entries are never dropped, duplicated or reordered.
- Handshake:
  - `in_ready` = buffer not full.
  - `out_valid` = buffer not empty.
  - The head entry pops when `out_valid` && `out_ready`.
- Simultaneous push and pop:
  - Allowed when the buffer holds 1 entry; occupancy stays at 1.
  - When full, `in_ready` is 0, so no push can occur that cycle; a pop that cycle frees one slot for the next cycle.
  - When empty, a push makes the word visible the next cycle. There is no combinational bypass to `out_data`.
- Holding rules:
  - `out_data` and `out_illegal` stay stable while `out_valid` && !`out_ready`.
  - When empty, `out_data` and `out_illegal` hold their last values.

## Timing
- Combinational path: 0 cycles.
- Registered path: 1 cycle from accept to `out_valid`.
- Throughput: 1 word per cycle while `out_ready` stays high.
- Reset state (asynchronous, while `rst_n` = 0): `out_valid` = 0, `out_data` = 0, `out_illegal` = 0, buffer empty, `illegal_count` = 0.
- `in_ready` is 0 while `rst_n` = 0 and 1 from the first edge after release.
- Reset asserted mid-transfer discards all buffered entries immediately.

## Configuration
- `EXPANDER_STATS_EN` defined:
  - `illegal_count` exists.
  - It increments by 1 on each accepted word with `illegal` = 1.
  - It saturates at all-ones and never wraps.
  - It is cleared only by reset.
- `EXPANDER_STATS_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `rvc_expander_pkg`:
  - constants `VALID_TAG_DEFAULT` and `ILLEGAL_WORD_DEFAULT`;
  - typedef `cword_t` (16 bits) and `xword_t` (32 bits);
  - packed struct `xentry_t` = {`xword_t` data, logic illegal}.
- One sub-module, `rvc_expander_skid`: the 2-entry valid/ready buffer of `xentry_t`.
- The expansion function lives in the top module and is shared by both paths.

## Test plan
- Combinational path, no clock required:
  - `compressed` = 16'h0000 -> `expanded` = 32'h0001_0000, `illegal` = 1.
  - `compressed` = 16'hFFFF -> `expanded` = 32'hFFFF_0001, `illegal` = 0.
  - `compressed` = 16'h1234 -> `expanded` = 32'h1234_0001, `illegal` = 0.
- Registered path, single word: `out_ready` = 1; push 16'h1234 -> next cycle `out_valid` = 1, `out_data` = 32'h1234_0001.
- Backpressure: `out_ready` = 0; push 16'hFFFF, 16'h0001, 16'h0002:
  - `in_ready` drops after 2 accepts and the third word is held.
  - Raise `out_ready` -> outputs 32'hFFFF_0001, 32'h0001_0001, 32'h0002_0001 in order, one per cycle.
- Stats with `EXPANDER_STATS_EN`, `COUNT_W` = 2:
  - Accept 5 zero words -> `illegal_count` = 3 (saturated).
  - Assert `rst_n` = 0 mid-stream -> `out_valid` = 0 and `illegal_count` = 0 immediately, without a clock edge.
